// File: rtl/magnitude_pkg.sv
// Shared widths and pipeline-split helpers for the magnitude unit.
package magnitude_pkg;

    localparam int DEF_DATA_IN_BITS = 16;

    function automatic int sum_bits(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int out_bits(input int w);
        return w + 1;
    endfunction

    // Earlier stages absorb the remainder when iterations do not split evenly.
    function automatic int stage_iters(input int s, input int iters, input int stages);
        return iters / stages + ((s < iters % stages) ? 1 : 0);
    endfunction

    function automatic int iters_before(input int s, input int iters, input int stages);
        int n;
        n = 0;
        for (int i = 0; i < s; i++) begin
            n += stage_iters(i, iters, stages);
        end
        return n;
    endfunction

endpackage

// File: rtl/magnitude_sqrt_pipe.sv
// Pipelined restoring integer square root, one result bit per iteration, MSB first.
module sqrt_pipe
    import magnitude_pkg::*;
#(
    parameter int IN_BITS  = 33,
    parameter int OUT_BITS = 17,
    parameter int STAGES   = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int RW = 2 * OUT_BITS;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int IT = stage_iters(s, OUT_BITS, STAGES);
        localparam int HI = OUT_BITS - 1 - iters_before(s, OUT_BITS, STAGES);

        logic [RW-1:0]       rem_in;
        logic [RW-1:0]       rem_nx;
        logic [RW-1:0]       trial;
        logic [OUT_BITS-1:0] root_in;
        logic [OUT_BITS-1:0] root_nx;
        logic [OUT_BITS-1:0] root_r;
        logic                valid_in;
        logic                valid_r;

        if (s == 0) begin : g_head
            assign rem_in   = RW'(in_data);
            assign root_in  = '0;
            assign valid_in = in_valid;
        end else begin : g_link
            assign rem_in   = g_stage[s-1].g_rem.rem_r;
            assign root_in  = g_stage[s-1].root_r;
            assign valid_in = g_stage[s-1].valid_r;
        end

        // rem holds x - root^2; setting bit k costs (2*root + 2^k) * 2^k.
        always_comb begin
            rem_nx  = rem_in;
            root_nx = root_in;
            trial   = '0;
            for (int j = 0; j < IT; j++) begin
                trial = (RW'(root_nx) << (HI - j + 1)) | (RW'(1) << (2 * (HI - j)));
                if (rem_nx >= trial) begin
                    rem_nx  = rem_nx - trial;
                    root_nx = root_nx | (OUT_BITS'(1) << (HI - j));
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_r <= 1'b0;
                root_r  <= '0;
            end else begin
                valid_r <= valid_in;
                if (valid_in) begin
                    root_r <= root_nx;
                end
            end
        end

        if (s < STAGES - 1) begin : g_rem
            logic [RW-1:0] rem_r;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rem_r <= '0;
                end else if (valid_in) begin
                    rem_r <= rem_nx;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_r;
    assign out_data  = g_stage[STAGES-1].root_r;

endmodule

// File: rtl/magnitude.sv
// Streaming magnitude: floor(sqrt(a^2 + b^2)) with fixed latency 1 + SQUARE_ROOT_BITS.
module magnitude
    import magnitude_pkg::*;
#(
    parameter  int SQUARE_ROOT_BITS    = 13,
    parameter  int DATA_IN_BITS        = DEF_DATA_IN_BITS,
    localparam int SQUARE_SUM_OUT_BITS = sum_bits(DATA_IN_BITS),
    localparam int DATA_OUT_BITS       = out_bits(DATA_IN_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_in_ready,
    input  logic [DATA_IN_BITS-1:0]  data_in_1,
    input  logic [DATA_IN_BITS-1:0]  data_in_2,
    output logic                     data_out_ready,
    output logic [DATA_OUT_BITS-1:0] data_out
);

    localparam int PW = 2 * DATA_IN_BITS;

    logic signed [PW-1:0]            ext_1;
    logic signed [PW-1:0]            ext_2;
    logic        [PW-1:0]            sq_1;
    logic        [PW-1:0]            sq_2;
    logic [SQUARE_SUM_OUT_BITS-1:0]  square_sum;
    logic [SQUARE_SUM_OUT_BITS-1:0]  square_sum_out;
    logic                            square_sum_out_ready;

    // Squares are non-negative and fit PW bits, so the low product bits are exact.
    assign ext_1      = {{DATA_IN_BITS{data_in_1[DATA_IN_BITS-1]}}, data_in_1};
    assign ext_2      = {{DATA_IN_BITS{data_in_2[DATA_IN_BITS-1]}}, data_in_2};
    assign sq_1       = ext_1 * ext_1;
    assign sq_2       = ext_2 * ext_2;
    assign square_sum = {1'b0, sq_1} + {1'b0, sq_2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            square_sum_out_ready <= 1'b0;
            square_sum_out       <= '0;
        end else begin
            square_sum_out_ready <= data_in_ready;
            if (data_in_ready) begin
                square_sum_out <= square_sum;
            end
        end
    end

    sqrt_pipe #(
        .IN_BITS  (SQUARE_SUM_OUT_BITS),
        .OUT_BITS (DATA_OUT_BITS),
        .STAGES   (SQUARE_ROOT_BITS)
    ) u_sqrt (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (square_sum_out_ready),
        .in_data   (square_sum_out),
        .out_valid (data_out_ready),
        .out_data  (data_out)
    );

endmodule

// File: tb/tb_magnitude.sv
// Directed and streamed checks of the magnitude unit against hand values and an isqrt model.
module tb_magnitude;

    logic        clk;
    logic        rst;
    logic        data_in_ready;
    logic [15:0] data_in_1;
    logic [15:0] data_in_2;
    logic        data_out_ready;
    logic [16:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        longint sum;
        longint mag;
        int     t;
    } exp_t;

    exp_t q_sum[$];
    exp_t q_mag[$];

    magnitude dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_ready  (data_in_ready),
        .data_in_1      (data_in_1),
        .data_in_2      (data_in_2),
        .data_out_ready (data_out_ready),
        .data_out       (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest pending entry and its latency.
    always @(negedge clk) begin
        if (rst) begin
            if (dut.square_sum_out_ready) begin
                check("sum_pending", 64'(q_sum.size() != 0), 64'd1);
                if (q_sum.size() != 0) begin
                    exp_t e;
                    e = q_sum.pop_front();
                    check("sum", 64'(dut.square_sum_out), 64'(e.sum));
                    check("sum_lat", 64'(cyc), 64'(e.t));
                end
            end
            if (data_out_ready) begin
                check("mag_pending", 64'(q_mag.size() != 0), 64'd1);
                if (q_mag.size() != 0) begin
                    exp_t e;
                    e = q_mag.pop_front();
                    check("mag", 64'(data_out), 64'(e.mag));
                    check("mag_lat", 64'(cyc), 64'(e.t + 13));
                end
            end
        end
    end

    task automatic send(input int a, input int b, input longint s, input longint m);
        exp_t e;
        @(negedge clk);
        data_in_1     = a[15:0];
        data_in_2     = b[15:0];
        data_in_ready = 1'b1;
        e.sum = s;
        e.mag = m;
        e.t   = cyc + 1;
        q_sum.push_back(e);
        q_mag.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_in_ready = 1'b0;
        end
    endtask

    function automatic longint isqrt(input longint s);
        longint r;
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    initial begin
        rst           = 1'b0;
        data_in_ready = 1'b0;
        data_in_1     = '0;
        data_in_2     = '0;
        repeat (2) @(negedge clk);
        check("rst_out_ready", 64'(data_out_ready), 64'd0);
        check("rst_out", 64'(data_out), 64'd0);
        check("rst_sum_ready", 64'(dut.square_sum_out_ready), 64'd0);
        check("rst_sum", 64'(dut.square_sum_out), 64'd0);
        rst = 1'b1;

        send(3, 4, 25, 5);
        idle(16);

        send(0, 0, 0, 0);
        send(1, 1, 2, 1);
        send(-5, 12, 169, 13);
        send(100, -100, 20000, 141);
        idle(2);

        send(-32768, -32768, 64'd2147483648, 46340);
        send(32767, 0, 1073676289, 32767);
        send(-32768, 32767, 2147418113, 46340);
        idle(2);

        send(6, 8, 100, 10);
        idle(3);
        send(8, 15, 289, 17);
        idle(2);

        repeat (4) send(6, 8, 100, 10);
        idle(18);

        // Abort five samples mid-flight; nothing from them may emerge.
        send(1, 2, 5, 2);
        send(2, 3, 13, 3);
        send(4, 4, 32, 5);
        send(7, 1, 50, 7);
        send(9, 9, 162, 12);
        @(negedge clk);
        data_in_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_out_ready", 64'(data_out_ready), 64'd0);
        check("midrst_out", 64'(data_out), 64'd0);
        check("midrst_sum_ready", 64'(dut.square_sum_out_ready), 64'd0);
        check("midrst_sum", 64'(dut.square_sum_out), 64'd0);
        q_sum.delete();
        q_mag.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(20);
        send(3, 4, 25, 5);

        for (int i = 0; i < 10000; i++) begin
            int a;
            int b;
            longint s;
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
            s = longint'(a) * a + longint'(b) * b;
            send(a, b, s, isqrt(s));
        end
        idle(1);

        for (int i = 0; i < 40 && q_mag.size() != 0; i++) @(negedge clk);
        check("drain_sum", 64'(q_sum.size()), 64'd0);
        check("drain_mag", 64'(q_mag.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
